// File: rtl/tl_phase_sched.sv
// ----------------------------------------------------------------------------
// tl_phase_sched
// Timed, round-robin phase scheduler for a two-road intersection with
// protected left turns. Four approach requests (A, A-left, B, B-left) are
// served in rotation. Each green lasts at least MIN_GREEN cycles and, while
// contested, at most MAX_GREEN cycles. Every green is followed by YELLOW
// cycles of yellow and then one all-red clearance cycle.
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high; forces all-red idle
//   Ta/Tal  : road A straight / left-turn request (level)
//   Tb/Tbl  : road B straight / left-turn request (level)
//   La/Lb   : light codes 00 green, 01 yellow, 10 red, 11 left arrow
//   grant   : one-hot active phase {BL,B,AL,A}, zero outside green
//   timer   : cycle count within the current interval (debug)
//   ped_req : pedestrian request (only with TL_PED_EN)
//   walk    : walk indication (only with TL_PED_EN)
//
// Build option
//   TL_PED_EN : adds the pedestrian request/walk interval. A request is held
//               pending and served as an all-red WALK interval of MIN_GREEN
//               cycles at the next clearance, or straight from idle.
// ----------------------------------------------------------------------------
module tl_phase_sched #(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 12,
   parameter int YELLOW    = 2,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Ta,
   input  logic             Tal,
   input  logic             Tb,
   input  logic             Tbl,
`ifdef TL_PED_EN
   input  logic             ped_req,
   output logic             walk,
`endif
   output logic [1:0]       La,
   output logic [1:0]       Lb,
   output logic [3:0]       grant,
   output logic [CNT_W-1:0] timer
);

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_RED    = 2'b10;
   localparam logic [1:0] L_ARROW  = 2'b11;

   localparam logic [CNT_W-1:0] MING_LAST = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAXG_LAST = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Phase encoding: 0 = A, 1 = AL, 2 = B, 3 = BL (matches grant bit order)
`ifdef TL_PED_EN
   typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [1:0]       rr_q, rr_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       la_q, la_d;
   logic [1:0]       lb_q, lb_d;
   logic [3:0]       grant_q, grant_d;

   logic [3:0]       req;
   logic [2:0]       sel;
   logic             own;
   logic             other;

`ifdef TL_PED_EN
   logic             pend_q, pend_d;
   logic             walk_q, walk_d;
   logic             ped_any;
`endif

   assign req = {Tbl, Tb, Tal, Ta};

   // Round-robin pick: returns {found, phase}. Scanning from the farthest
   // offset down lets the offset closest to ptr overwrite, so ptr wins ties.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Next-state logic
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rr_d    = rr_q;
      timer_d = timer_q;
      sel     = rr_pick(req, rr_q);
      own     = req[phase_q];
      other   = |(req & ~(4'b0001 << phase_q));
`ifdef TL_PED_EN
      ped_any = pend_q | ped_req;
      pend_d  = ped_any;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef TL_PED_EN
            if (ped_any) begin
               state_d = S_WALK;
            end else
`endif
            if (sel[2]) begin
               state_d = S_GREEN;
               phase_d = sel[1:0];
            end
         end

         S_GREEN: begin
            // Yield only to a competing request, once minimum green is
            // met, and only if our own demand is gone or max green is hit.
            if (other && (timer_q >= MING_LAST) && (!own || (timer_q == MAXG_LAST))) begin
               state_d = S_YELLOW;
            end else if (timer_q != MAXG_LAST) begin
               timer_d = timer_q + CNT_ONE;
            end
         end

         S_YELLOW: begin
            if (timer_q == YEL_LAST) begin
               state_d = S_ALLRED;
               // The served phase drops to lowest priority for the next pick.
               rr_d    = phase_q + 2'd1;
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end

         S_ALLRED: begin
`ifdef TL_PED_EN
            if (ped_any) begin
               state_d = S_WALK;
            end else
`endif
            if (sel[2]) begin
               state_d = S_GREEN;
               phase_d = sel[1:0];
            end else begin
               state_d = S_IDLE;
            end
         end

`ifdef TL_PED_EN
         S_WALK: begin
            if (timer_q == MING_LAST) begin
               if (sel[2]) begin
                  state_d = S_GREEN;
                  phase_d = sel[1:0];
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) timer_d = '0;

`ifdef TL_PED_EN
      if ((state_d == S_WALK) && (state_q != S_WALK)) pend_d = 1'b0;
`endif
   end

   // Moore outputs, computed from the next state so they register with it
   always_comb begin
      la_d    = L_RED;
      lb_d    = L_RED;
      grant_d = 4'b0000;
`ifdef TL_PED_EN
      walk_d  = (state_d == S_WALK);
`endif
      case (state_d)
         S_GREEN: begin
            grant_d = 4'b0001 << phase_d;
            case (phase_d)
               2'd0:    la_d = L_GREEN;
               2'd1:    la_d = L_ARROW;
               2'd2:    lb_d = L_GREEN;
               default: lb_d = L_ARROW;
            endcase
         end
         S_YELLOW: begin
            // Left-arrow phases also clear through plain yellow.
            if (!phase_d[1]) la_d = L_YELLOW;
            else             lb_d = L_YELLOW;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= 2'd0;
         rr_q    <= 2'd0;
         timer_q <= '0;
         la_q    <= L_RED;
         lb_q    <= L_RED;
         grant_q <= 4'b0000;
`ifdef TL_PED_EN
         pend_q  <= 1'b0;
         walk_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rr_q    <= rr_d;
         timer_q <= timer_d;
         la_q    <= la_d;
         lb_q    <= lb_d;
         grant_q <= grant_d;
`ifdef TL_PED_EN
         pend_q  <= pend_d;
         walk_q  <= walk_d;
`endif
      end
   end

   assign La    = la_q;
   assign Lb    = lb_q;
   assign grant = grant_q;
   assign timer = timer_q;
`ifdef TL_PED_EN
   assign walk  = walk_q;
`endif

endmodule
